// File: rtl/alu_wb_stage.sv
// alu_wb_stage: two-entry writeback buffer between the ALU and a shared register-file write port,
// with head forwarding, zero/negative flags of the last retired result and a retire counter.
module alu_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [REG_AW-1:0] in_rd_i,
  input  logic              in_we_i,
  input  logic              flush_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [REG_AW-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              fwd_valid_o,
  output logic [REG_AW-1:0] fwd_rd_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic              flag_z_o,
  output logic              flag_n_o,
  output logic [15:0]       retired_cnt_o
);
  logic [REG_AW-1:0] rd_q [2];
  logic [DATA_W-1:0] data_q [2];
  logic              wp_q, wp_d, rp_q, rp_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              flag_z_q, flag_z_d, flag_n_q, flag_n_d;
  logic [15:0]       ret_cnt_q, ret_cnt_d;
  logic              acc, enq, ret;
  assign in_ready_o    = (cnt_q != 2'd2);
  assign wb_valid_o    = (cnt_q != 2'd0);
  assign wb_addr_o     = rd_q[rp_q];
  assign wb_data_o     = data_q[rp_q];
  assign fwd_valid_o   = wb_valid_o;
  assign fwd_rd_o      = wb_addr_o;
  assign fwd_data_o    = wb_data_o;
  assign flag_z_o      = flag_z_q;
  assign flag_n_o      = flag_n_q;
  assign retired_cnt_o = ret_cnt_q;
  // Results that write nothing (no we, or x0) are consumed here and never reach the port.
  always_comb begin
    acc       = in_valid_i & in_ready_o;
    enq       = acc & in_we_i & (in_rd_i != '0) & ~flush_i;
    ret       = wb_valid_o & wb_ready_i;
    cnt_d     = flush_i ? 2'd0 : cnt_q + {1'b0, enq} - {1'b0, ret};
    wp_d      = flush_i ? 1'b0 : wp_q ^ enq;
    rp_d      = flush_i ? 1'b0 : rp_q ^ ret;
    flag_z_d  = ret ? (wb_data_o == '0) : flag_z_q;
    flag_n_d  = ret ? wb_data_o[DATA_W-1] : flag_n_q;
    ret_cnt_d = ret_cnt_q + {15'd0, ret};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q[0]   <= '0;
      rd_q[1]   <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      cnt_q     <= 2'd0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      ret_cnt_q <= 16'd0;
    end else begin
      if (enq) begin
        rd_q[wp_q]   <= in_rd_i;
        data_q[wp_q] <= in_data_i;
      end
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      flag_z_q  <= flag_z_d;
      flag_n_q  <= flag_n_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end
endmodule
